// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle rs1 - rs2 comparator for branch resolution.
// Subtracts STEP bits per cycle, LSB slice first. It produces the zero, carry,
// sign and overflow flags plus the branch code that travels with the operands.
// Optional feature macro: CMP_DIFF_OUT_EN adds the full difference output 'diff'.
`timescale 1ns/1ps

module branch_cmp_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      branch_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      branch_out,
    output logic            zero,
    output logic            carry,
    output logic            sign,
`ifdef CMP_DIFF_OUT_EN
    output logic            overflow,
    output logic [XLEN-1:0] diff
`else
    output logic            overflow
`endif
);

    localparam int NSLICE = XLEN / STEP;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_cin;
    logic              r_zero_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [2:0]        r_branch;
    logic              r_zero;
    logic              r_carry;
    logic              r_sign;
    logic              r_overflow;

    // The operand registers shift right by STEP each CALC cycle, so the
    // current slice always sits in the low STEP bits and no variable index
    // is needed.
    logic [STEP-1:0]   w_a_slice;
    logic [STEP-1:0]   w_b_slice;
    logic [STEP:0]     w_sum;
    logic [STEP-1:0]   w_res;
    logic              w_cout;
    logic              w_last;

    assign w_a_slice = r_a[STEP-1:0];
    assign w_b_slice = r_b[STEP-1:0];
    assign w_sum     = {1'b0, w_a_slice} + {1'b0, ~w_b_slice} + {{STEP{1'b0}}, r_cin};
    assign w_res     = w_sum[STEP-1:0];
    assign w_cout    = w_sum[STEP];
    assign w_last    = (r_cnt == CNT_W'(NSLICE - 1));

`ifdef CMP_DIFF_OUT_EN
    logic [XLEN-1:0] r_diff;
    logic [XLEN-1:0] w_diff_next;

    // Result slices enter at the top and shift down, so after the last slice
    // the register holds the difference in natural bit order.
    if (NSLICE == 1) begin : g_diff_single
        assign w_diff_next = w_res;
    end else begin : g_diff_shift
        assign w_diff_next = {w_res, r_diff[XLEN-1:STEP]};
    end

    // Difference register: cleared on reset, filled one slice per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff <= '0;
        end else if (!flush && (r_state == CALC)) begin
            r_diff <= w_diff_next;
        end
    end

    assign diff = r_diff;
`endif

    // Control FSM with registered handshake outputs and flag registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_zero_acc  <= 1'b0;
            r_cnt       <= '0;
            // NOTE: in_ready is a register, so it reads 0 for the whole
            // time rst_n is low and rises only on the first edge after release.
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_branch    <= 3'b000;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_sign      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            // Redirect aborts any compare. The flags keep stale values,
            // which is harmless because out_valid is cleared.
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= rs1;
                        r_b        <= rs2;
                        r_branch   <= branch_in;
                        r_cin      <= 1'b1;
                        r_zero_acc <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_a        <= r_a >> STEP;
                    r_b        <= r_b >> STEP;
                    r_cin      <= w_cout;
                    r_zero_acc <= r_zero_acc | (|w_res);
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_zero      <= ~(r_zero_acc | (|w_res));
                        r_carry     <= w_cout;
                        r_sign      <= w_res[STEP-1];
                        r_overflow  <= (w_a_slice[STEP-1] != w_b_slice[STEP-1]) &&
                                       (w_res[STEP-1] != w_a_slice[STEP-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign branch_out = r_branch;
    assign zero       = r_zero;
    assign carry      = r_carry;
    assign sign       = r_sign;
    assign overflow   = r_overflow;

endmodule
